systolic_array_2x2: RTL and testbench
=====================================

// Module: systolic_array_2x2
// PURPOSE
// - 2x2 output-stationary systolic array for 8-bit matrix multiply C = A x B.
// - Row operands enter on the left edge (a1, a2) and column operands on the top edge (b1, b2).
// - Operands ripple right and down through registered PEs; each PE holds one C element.
// - Standalone compute tile, fed by an upstream skew/sequencer that supplies pre-skewed streams.
// PARAMETERS
// - none; all datapaths are fixed at 8 bits.
// PORTS
// clk    in   1  system clock; all state updates on rising edge
// reset  in   1  synchronous, active-high; clears all state
// a1     in   8  row-1 operand stream, enters PE11
// a2     in   8  row-2 operand stream, enters PE21
// b1     in   8  column-1 operand stream, enters PE11
// b2     in   8  column-2 operand stream, enters PE12
// c1     out  8  accumulator of PE11 (C11)
// c2     out  8  accumulator of PE12 (C12)
// c3     out  8  accumulator of PE21 (C21)
// c4     out  8  accumulator of PE22 (C22)
// BEHAVIOUR
// - Clock and reset: one clock domain; reset is synchronous and active-high.
// - PE structure:
//   - Each PE(i,j) has registers a_q, b_q, acc (all 8 bits).
//   - Each rising edge with reset=0: acc <= acc + a_in*b_in; a_q <= a_in; b_q <= b_in.
// - Interconnect:
//   - PE11: a_in=a1, b_in=b1.
//   - PE12: a_in=PE11.a_q, b_in=b2.
//   - PE21: a_in=a2, b_in=PE11.b_q.
//   - PE22: a_in=PE21.a_q, b_in=PE12.b_q.
// - Outputs: c1..c4 come directly from the acc registers; no combinational path from inputs to outputs.
// - Arithmetic: product truncated to low 8 bits; sum wraps modulo 256; unsigned; no saturation, no overflow flag.
// - Reset:
//   - Every edge with reset=1 clears all a_q, b_q and acc to 0, so c1..c4 = 0.
//   - Reset mid-operation discards in-flight operands and partial sums.
// - No clear-on-start: accumulators keep summing until reset. Zero operands are the only idle/no-op input.
// - Feeding convention (upstream duty, edge k = k-th sampling edge):
//   - Edge 0: a1=A11, b1=B11.
//   - Edge 1: a1=A12, b1=B21, a2=A21, b2=B12.
//   - Edge 2: a2=A22, b2=B22.
//   - Every other slot is 0.
// - Latency (counted from edge 0):
//   - c1 final after edge 1.
//   - c2 and c3 final after edge 2.
//   - c4 final after edge 3.
// - Back-to-back matrices: no internal flush; non-zero operands keep adding to the existing accumulators.
// TESTING
// - Reset: hold reset 2 cycles with non-zero inputs -> c1..c4 = 0 and all pipeline regs = 0.
// - Basic multiply: A=[[1,2],[3,4]], B=[[5,6],[7,8]], skewed feed then zeros
//   -> after edge 3: c1=19, c2=22, c3=43, c4=50; values stay stable while inputs remain 0.
// - Latency: same stimulus -> c1=5 after edge 0; c1=19 after edge 1; c2=22 and c3=43 after edge 2;
//   c4=50 only after edge 3.
// - Wrap: a1=16, b1=16 for one edge -> c1=0; a1=15, b1=17 for one edge -> c1=255, then another
//   a1=1, b1=1 -> c1=0.
// - Forwarding: a1=3, b1=0, b2=2 on edge 0, then b2=2 on edge 1 -> c1=0, c2=6; c3=0; c4 unchanged.
// - Reset mid-run: assert reset after edge 1 of the basic multiply -> all outputs 0; re-feeding the full
//   sequence yields 19/22/43/50 again.

Source files
------------

// File: rtl/systolic_array_2x2.sv
// 2x2 output-stationary systolic array computing C = A x B on 8-bit unsigned data.
// Row operands ripple right and column operands ripple down through registered PEs.

module systolic_pe (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a_in,
    input  logic [7:0] b_in,
    output logic [7:0] a_q,
    output logic [7:0] b_q,
    output logic [7:0] acc
);

    logic [7:0] prod;

    // Only the low byte of the product survives; the sum wraps modulo 256.
    assign prod = a_in * b_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q <= 8'd0;
            b_q <= 8'd0;
            acc <= 8'd0;
        end else begin
            a_q <= a_in;
            b_q <= b_in;
            acc <= acc + prod;
        end
    end

endmodule

module systolic_array_2x2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] a1,
    input  logic [7:0] a2,
    input  logic [7:0] b1,
    input  logic [7:0] b2,
    output logic [7:0] c1,
    output logic [7:0] c2,
    output logic [7:0] c3,
    output logic [7:0] c4
);

    // Index order: 0 = PE11, 1 = PE12, 2 = PE21, 3 = PE22.
    logic [7:0] a_q [4];
    logic [7:0] b_q [4];
    logic [7:0] acc [4];

    systolic_pe pe11 (
        .clk   (clk),
        .reset (reset),
        .a_in  (a1),
        .b_in  (b1),
        .a_q   (a_q[0]),
        .b_q   (b_q[0]),
        .acc   (acc[0])
    );

    systolic_pe pe12 (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_q[0]),
        .b_in  (b2),
        .a_q   (a_q[1]),
        .b_q   (b_q[1]),
        .acc   (acc[1])
    );

    systolic_pe pe21 (
        .clk   (clk),
        .reset (reset),
        .a_in  (a2),
        .b_in  (b_q[0]),
        .a_q   (a_q[2]),
        .b_q   (b_q[2]),
        .acc   (acc[2])
    );

    // PE22 sits on the bottom-right edge, so its forwarded operands go nowhere.
    systolic_pe pe22 (
        .clk   (clk),
        .reset (reset),
        .a_in  (a_q[2]),
        .b_in  (b_q[1]),
        .a_q   (a_q[3]),
        .b_q   (b_q[3]),
        .acc   (acc[3])
    );

    assign c1 = acc[0];
    assign c2 = acc[1];
    assign c3 = acc[2];
    assign c4 = acc[3];

endmodule

// File: tb/tb_systolic_array_2x2.sv
// Self-checking bench for systolic_array_2x2: vector table plus matrix-model sequences,
// with expected outputs queued at drive time and compared after each edge.

module tb_systolic_array_2x2;

    logic       clk;
    logic       reset;
    logic [7:0] a1, a2, b1, b2;
    logic [7:0] c1, c2, c3, c4;

    systolic_array_2x2 dut (
        .clk   (clk),
        .reset (reset),
        .a1    (a1),
        .a2    (a2),
        .b1    (b1),
        .b2    (b2),
        .c1    (c1),
        .c2    (c2),
        .c3    (c3),
        .c4    (c4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [7:0] a1, a2, b1, b2;
        logic [7:0] e1, e2, e3, e4;
    } vec_t;

    typedef struct {
        int         tag;
        logic [7:0] e1, e2, e3, e4;
    } exp_t;

    vec_t vecs [$];
    exp_t sb [$];

    int n_cmp = 0;
    int n_bad = 0;
    int tag_ctr = 0;

    function automatic void add(input logic rst,
                                input logic [7:0] xa1, xa2, xb1, xb2,
                                input logic [7:0] x1, x2, x3, x4);
        vec_t v;
        v.rst = rst;
        v.a1 = xa1; v.a2 = xa2; v.b1 = xb1; v.b2 = xb2;
        v.e1 = x1;  v.e2 = x2;  v.e3 = x3;  v.e4 = x4;
        vecs.push_back(v);
    endfunction

    // Drive one edge's inputs, queue the expected outputs, then check after the edge.
    task automatic step(input logic rst,
                        input logic [7:0] xa1, xa2, xb1, xb2,
                        input logic [7:0] x1, x2, x3, x4);
        exp_t e;
        exp_t got;
        @(negedge clk);
        reset = rst;
        a1 = xa1; a2 = xa2; b1 = xb1; b2 = xb2;
        e.tag = tag_ctr;
        e.e1 = x1; e.e2 = x2; e.e3 = x3; e.e4 = x4;
        sb.push_back(e);
        tag_ctr++;
        @(posedge clk);
        #1;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $display("FAIL step %0d: scoreboard empty", tag_ctr);
        end else begin
            got = sb.pop_front();
            if ({c1, c2, c3, c4} !== {got.e1, got.e2, got.e3, got.e4}) begin
                n_bad++;
                $display("FAIL step %0d: got c=%0d/%0d/%0d/%0d required %0d/%0d/%0d/%0d",
                         got.tag, c1, c2, c3, c4, got.e1, got.e2, got.e3, got.e4);
            end
        end
    endtask

    // Feed one matrix pair with the skewed schedule and check every edge against
    // partial sums derived from the matrix product.
    task automatic feed(input logic [7:0] am [2][2], input logic [7:0] bm [2][2],
                        input logic [7:0] base [4]);
        logic [7:0] c11, c12, c21, c22;
        logic [7:0] p1112, p2111, p2112;
        c11   = am[0][0] * bm[0][0] + am[0][1] * bm[1][0];
        c12   = am[0][0] * bm[0][1] + am[0][1] * bm[1][1];
        c21   = am[1][0] * bm[0][0] + am[1][1] * bm[1][0];
        c22   = am[1][0] * bm[0][1] + am[1][1] * bm[1][1];
        p1112 = am[0][0] * bm[0][1];
        p2111 = am[1][0] * bm[0][0];
        p2112 = am[1][0] * bm[0][1];
        step(1'b0, am[0][0], 8'd0, bm[0][0], 8'd0,
             base[0] + 8'(am[0][0] * bm[0][0]), base[1], base[2], base[3]);
        step(1'b0, am[0][1], am[1][0], bm[1][0], bm[0][1],
             base[0] + c11, base[1] + p1112, base[2] + p2111, base[3]);
        step(1'b0, 8'd0, am[1][1], 8'd0, bm[1][1],
             base[0] + c11, base[1] + c12, base[2] + c21, base[3] + p2112);
        step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0,
             base[0] + c11, base[1] + c12, base[2] + c21, base[3] + c22);
        step(1'b0, 8'd0, 8'd0, 8'd0, 8'd0,
             base[0] + c11, base[1] + c12, base[2] + c21, base[3] + c22);
    endtask

    initial begin
        logic [7:0] am [2][2];
        logic [7:0] bm [2][2];
        logic [7:0] zero4 [4];
        logic [7:0] base [4];
        logic [7:0] t1, t2, t3, t4;

        reset = 1'b1;
        a1 = 8'd0; a2 = 8'd0; b1 = 8'd0; b2 = 8'd0;

        // Reset held with non-zero inputs.
        add(1, 8'd9, 8'd8, 8'd7, 8'd6,   0, 0, 0, 0);
        add(1, 8'd255, 8'd1, 8'd3, 8'd4, 0, 0, 0, 0);
        // Basic multiply with latency checks, then idle stability.
        add(0, 1, 0, 5, 0,  5,  0,  0,  0);
        add(0, 2, 3, 7, 6, 19,  6, 15,  0);
        add(0, 0, 4, 0, 8, 19, 22, 43, 18);
        add(0, 0, 0, 0, 0, 19, 22, 43, 50);
        add(0, 0, 0, 0, 0, 19, 22, 43, 50);
        add(0, 0, 0, 0, 0, 19, 22, 43, 50);
        // Back-to-back: no flush, results accumulate.
        add(0, 1, 0, 5, 0, 24, 22, 43, 50);
        add(0, 2, 3, 7, 6, 38, 28, 58, 50);
        add(0, 0, 4, 0, 8, 38, 44, 86, 68);
        add(0, 0, 0, 0, 0, 38, 44, 86, 100);
        // Wrap modulo 256.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 16, 0, 16, 0, 0, 0, 0, 0);
        add(0, 15, 0, 17, 0, 255, 0, 0, 0);
        add(0, 1, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0);
        // Forwarding of a1 into PE12.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 3, 0, 0, 2, 0, 0, 0, 0);
        add(0, 0, 0, 0, 2, 0, 6, 0, 0);
        add(0, 0, 0, 0, 0, 0, 6, 0, 0);
        // Reset mid-run, then full re-feed.
        add(1, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 1, 0, 5, 0,  5,  0,  0,  0);
        add(0, 2, 3, 7, 6, 19,  6, 15,  0);
        add(1, 0, 4, 0, 8,  0,  0,  0,  0);
        add(0, 1, 0, 5, 0,  5,  0,  0,  0);
        add(0, 2, 3, 7, 6, 19,  6, 15,  0);
        add(0, 0, 4, 0, 8, 19, 22, 43, 18);
        add(0, 0, 0, 0, 0, 19, 22, 43, 50);

        repeat (2) @(posedge clk);

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].a1, vecs[i].a2, vecs[i].b1, vecs[i].b2,
                 vecs[i].e1, vecs[i].e2, vecs[i].e3, vecs[i].e4);

        // Random matrices checked against the matrix product, fresh and accumulated.
        for (int k = 0; k < 6; k++) begin
            for (int r = 0; r < 2; r++)
                for (int c = 0; c < 2; c++) begin
                    am[r][c] = 8'($urandom_range(0, 255));
                    bm[r][c] = 8'($urandom_range(0, 255));
                end
            for (int j = 0; j < 4; j++) zero4[j] = 8'd0;
            if (k % 2 == 0) begin
                step(1'b1, 8'd0, 8'd0, 8'd0, 8'd0, 0, 0, 0, 0);
                feed(am, bm, zero4);
            end else begin
                t1 = c1; t2 = c2; t3 = c3; t4 = c4;
                base[0] = t1; base[1] = t2; base[2] = t3; base[3] = t4;
                feed(am, bm, base);
            end
        end

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard drain: %0d entries left, required 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
